// File: rtl/mult_ctrl_taint_radix_pkg.sv
// Shared definitions for the radix multiplier control FSM with taint tracking:
// state encoding and the digit-counter width helper.
package mult_taint_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t INIT  = 3'd1;
   localparam state_t ADD   = 3'd2;
   localparam state_t SHIFT = 3'd3;
   localparam state_t DONE  = 3'd4;

   // Digit counter width; a single-digit multiplier still needs a 1-bit counter.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_ctrl_taint_radix_if.sv
// Handshake, multiplier and control-strobe bundle between the controller (slave)
// and the datapath/requester side (master), each signal with its shadow taint.
interface mult_ctrl_taint_radix_if #(
   parameter int WIDTH = 1024,
   parameter int DIGIT = 1
);
   logic             start, start_t;
   logic             abort, abort_t;
   logic [WIDTH-1:0] multiplierReg, multiplierReg_t;
   logic             busy, busy_t;
   logic             productDone, productDone_t;
   logic             mdld, mrld, rsclear, rsload, rsshr;
   logic             mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t;
   logic [DIGIT-1:0] digit_sel, digit_sel_t;

   modport master (
      output start, start_t, abort, abort_t, multiplierReg, multiplierReg_t,
      input  busy, busy_t, productDone, productDone_t,
      input  mdld, mrld, rsclear, rsload, rsshr,
      input  mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
      input  digit_sel, digit_sel_t
   );

   modport slave (
      input  start, start_t, abort, abort_t, multiplierReg, multiplierReg_t,
      output busy, busy_t, productDone, productDone_t,
      output mdld, mrld, rsclear, rsload, rsshr,
      output mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
      output digit_sel, digit_sel_t
   );
endinterface

// File: rtl/mult_ctrl_taint_radix_digit_mux.sv
// Selects multiplier digit `index` together with its taint, plus the
// nonzero flag and OR-reduced taint used for control decisions.
module mult_digit_mux_taint
   import mult_taint_pkg::*;
#(
   parameter int WIDTH = 1024,
   parameter int DIGIT = 1,
   localparam int IDX_W = idx_width(WIDTH / DIGIT)
) (
   input  logic [WIDTH-1:0] multiplierReg,
   input  logic [WIDTH-1:0] multiplierReg_t,
   input  logic [IDX_W-1:0] index,
   output logic [DIGIT-1:0] digit,
   output logic [DIGIT-1:0] digit_t,
   output logic             digit_nz,
   output logic             digit_any_t
);

   // A shift keeps out-of-range indices (counter wrap past the last digit) at zero.
   assign digit       = DIGIT'(multiplierReg   >> (index * DIGIT));
   assign digit_t     = DIGIT'(multiplierReg_t >> (index * DIGIT));
   assign digit_nz    = |digit;
   assign digit_any_t = |digit_t;

endmodule

// File: rtl/mult_ctrl_taint_radix.sv
// Radix-2^DIGIT shift-add multiplier controller: Moore FSM with digit counter,
// busy/done/abort handshake and a sticky control-flow taint bit.
module mult_ctrl_taint_radix
   import mult_taint_pkg::*;
#(
   parameter int WIDTH = 1024,
   parameter int DIGIT = 1
) (
   input logic clk,
   input logic rst,
   mult_ctrl_taint_radix_if.slave bus
);

   localparam int N     = WIDTH / DIGIT;
   localparam int IDX_W = idx_width(N);

   if (WIDTH % DIGIT != 0) begin : g_width_check
      $error("mult_ctrl_taint_radix: WIDTH must be a multiple of DIGIT");
   end

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d, nxt_idx;
   logic               ctl_t_q, ctl_t_d, dec_t;
   logic               last;
   logic [DIGIT-1:0]   cur_digit, cur_digit_t, nxt_digit, nxt_digit_t;
   logic               cur_nz, cur_any_t, nxt_nz, nxt_any_t;
   logic               unused_mux;

   assign last    = (idx_q == IDX_W'(N - 1));
   assign nxt_idx = (state_q == INIT) ? '0 : idx_q + 1'b1;

   mult_digit_mux_taint #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_cur_mux (
      .multiplierReg   (bus.multiplierReg),
      .multiplierReg_t (bus.multiplierReg_t),
      .index           (idx_q),
      .digit           (cur_digit),
      .digit_t         (cur_digit_t),
      .digit_nz        (cur_nz),
      .digit_any_t     (cur_any_t)
   );

   mult_digit_mux_taint #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_nxt_mux (
      .multiplierReg   (bus.multiplierReg),
      .multiplierReg_t (bus.multiplierReg_t),
      .index           (nxt_idx),
      .digit           (nxt_digit),
      .digit_t         (nxt_digit_t),
      .digit_nz        (nxt_nz),
      .digit_any_t     (nxt_any_t)
   );

   assign unused_mux = ^{cur_nz, cur_any_t, nxt_digit, nxt_digit_t};

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ctl_t_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ctl_t_q <= ctl_t_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dec_t   = 1'b0;
      case (state_q)
         IDLE:  if (bus.start) state_d = INIT;
         INIT: begin
            idx_d   = '0;
            dec_t   = nxt_any_t;
            state_d = nxt_nz ? ADD : SHIFT;
         end
         ADD:   state_d = SHIFT;
         SHIFT: begin
            if (last) begin
               state_d = DONE;
            end else begin
               idx_d   = nxt_idx;
               dec_t   = nxt_any_t;
               state_d = nxt_nz ? ADD : SHIFT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && bus.abort) begin
         state_d = IDLE;
         idx_d   = '0;
         dec_t   = 1'b0;
      end
      // Once control flow depends on tainted data, all later timing is tainted.
      ctl_t_d = ctl_t_q | dec_t | ((state_q == IDLE) ? bus.start_t : bus.abort_t);
   end

   always_comb begin
      bus.busy        = (state_q != IDLE);
      bus.productDone = (state_q == DONE);
      bus.mdld        = (state_q == INIT);
      bus.mrld        = (state_q == INIT);
      bus.rsclear     = (state_q == INIT);
      bus.rsload      = (state_q == ADD);
      bus.rsshr       = (state_q == SHIFT);
      bus.digit_sel   = (state_q == ADD) ? cur_digit : '0;

      bus.busy_t        = ctl_t_q;
      bus.productDone_t = ctl_t_q;
      bus.mdld_t        = ctl_t_q;
      bus.mrld_t        = ctl_t_q;
      bus.rsclear_t     = ctl_t_q;
      bus.rsload_t      = ctl_t_q;
      bus.rsshr_t       = ctl_t_q;
      bus.digit_sel_t   = {DIGIT{ctl_t_q}} | ((state_q == ADD) ? cur_digit_t : '0);
   end

endmodule

// File: tb/tb_mult_ctrl_taint_radix.sv
// Directed bench for mult_ctrl_taint_radix: three small instances (DIGIT = 2, 1, 4)
// checked cycle by cycle against hand-derived state sequences and taint values.
module tb_mult_ctrl_taint_radix;
   import mult_taint_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_ctrl_taint_radix_if #(.WIDTH(8), .DIGIT(2)) b2 ();
   mult_ctrl_taint_radix_if #(.WIDTH(8), .DIGIT(1)) b1 ();
   mult_ctrl_taint_radix_if #(.WIDTH(8), .DIGIT(4)) b4 ();

   mult_ctrl_taint_radix #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst(rst), .bus(b2));
   mult_ctrl_taint_radix #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(b1));
   mult_ctrl_taint_radix #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(b4));

   // {busy, productDone, mdld, mrld, rsclear, rsload, rsshr} and matching taints
   logic [6:0] ctl2, tnt2, ctl1, ctl4, tnt4;
   assign ctl2 = {b2.busy, b2.productDone, b2.mdld, b2.mrld, b2.rsclear, b2.rsload, b2.rsshr};
   assign tnt2 = {b2.busy_t, b2.productDone_t, b2.mdld_t, b2.mrld_t, b2.rsclear_t, b2.rsload_t, b2.rsshr_t};
   assign ctl1 = {b1.busy, b1.productDone, b1.mdld, b1.mrld, b1.rsclear, b1.rsload, b1.rsshr};
   assign ctl4 = {b4.busy, b4.productDone, b4.mdld, b4.mrld, b4.rsclear, b4.rsload, b4.rsshr};
   assign tnt4 = {b4.busy_t, b4.productDone_t, b4.mdld_t, b4.mrld_t, b4.rsclear_t, b4.rsload_t, b4.rsshr_t};

   localparam state_t     SEQ_A [9] = '{INIT, ADD, SHIFT, SHIFT, SHIFT, ADD, SHIFT, DONE, IDLE};
   localparam logic [1:0] SEL_A [9] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
   localparam state_t     SEQ_F [6] = '{INIT, SHIFT, ADD, SHIFT, DONE, IDLE};
   localparam logic [3:0] SEL_F [6] = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0};

   int n_checks = 0;
   int n_pass   = 0;
   int done_at;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [6:0] ctl_of(input state_t s);
      case (s)
         INIT:    return 7'b1011100;
         ADD:     return 7'b1000010;
         SHIFT:   return 7'b1000001;
         DONE:    return 7'b1100000;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      {b2.start, b2.start_t, b2.abort, b2.abort_t} = '0;
      {b1.start, b1.start_t, b1.abort, b1.abort_t} = '0;
      {b4.start, b4.start_t, b4.abort, b4.abort_t} = '0;
      b2.multiplierReg = '0; b2.multiplierReg_t = '0;
      b1.multiplierReg = '0; b1.multiplierReg_t = '0;
      b4.multiplierReg = '0; b4.multiplierReg_t = '0;

      // Reset state
      do_reset();
      check("reset_ctl", 32'(ctl2), 32'(7'b0));
      check("reset_taint", 32'(tnt2), 32'(7'b0));
      check("reset_sel_t", 32'(b2.digit_sel_t), 32'(2'b0));

      // Scenario 1: DIGIT=2, 10_00_00_01, untainted
      b2.multiplierReg = 8'b10_00_00_01;
      b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         check($sformatf("s1_ctl_c%0d", k), 32'(ctl2), 32'(ctl_of(SEQ_A[k-1])));
         check($sformatf("s1_sel_c%0d", k), 32'(b2.digit_sel), 32'(SEL_A[k-1]));
         check($sformatf("s1_taint_c%0d", k), 32'({tnt2, b2.digit_sel_t}), 32'(0));
         tick();
      end

      // Scenario 2: DIGIT=1 latency, all-ones then zero multiplier
      b1.multiplierReg = 8'hFF;
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      done_at = -1;
      for (int c = 1; c <= 40; c++) begin
         if (b1.productDone) begin done_at = c; break; end
         tick();
      end
      check("s2_done_ff", 32'(done_at), 32'(18));
      tick();
      check("s2_idle_ff", 32'(ctl1), 32'(7'b0));
      b1.multiplierReg = 8'h00;
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      done_at = -1;
      for (int c = 1; c <= 40; c++) begin
         if (b1.productDone) begin done_at = c; break; end
         tick();
      end
      check("s2_done_00", 32'(done_at), 32'(10));

      // Scenario 3: digit 1 tainted, control taint from c4 and sticky
      do_reset();
      b2.multiplierReg   = 8'b10_00_00_01;
      b2.multiplierReg_t = 8'h04;
      b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         check($sformatf("s3_ctl_c%0d", k), 32'(ctl2), 32'(ctl_of(SEQ_A[k-1])));
         check($sformatf("s3_taint_c%0d", k), 32'(tnt2), (k <= 3) ? 32'(0) : 32'(7'h7F));
         check($sformatf("s3_sel_t_c%0d", k), 32'(b2.digit_sel_t), (k <= 3) ? 32'(0) : 32'(2'b11));
         tick();
      end
      check("s3_sticky_idle", 32'(tnt2), 32'(7'h7F));
      do_reset();
      check("s3_rst_clears", 32'(tnt2), 32'(0));
      b2.multiplierReg_t = 8'h00;

      // Scenario 4: abort at c4, restart at c6
      b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      tick();
      tick();
      tick();
      check("s4_pre_abort", 32'(ctl2), 32'(ctl_of(SHIFT)));
      b2.abort = 1'b1;
      tick();
      b2.abort = 1'b0;
      check("s4_abort_idle", 32'(ctl2), 32'(7'b0));
      tick();
      check("s4_c6_idle", 32'(ctl2), 32'(7'b0));
      b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      done_at = -1;
      for (int c = 7; c <= 40; c++) begin
         if (b2.productDone) begin done_at = c; break; end
         tick();
      end
      check("s4_restart_done", 32'(done_at), 32'(14));
      check("s4_taint", 32'(tnt2), 32'(0));
      tick();

      // Scenario 5: tainted start, reset mid-operation, start held while busy
      do_reset();
      b2.start_t = 1'b1;
      b2.start   = 1'b1;
      tick();
      check("s5_init", 32'(ctl2), 32'(ctl_of(INIT)));
      check("s5_start_taint", 32'(tnt2), 32'(7'h7F));
      tick();
      check("s5_add", 32'(ctl2), 32'(ctl_of(ADD)));
      tick();
      check("s5_shift", 32'(ctl2), 32'(ctl_of(SHIFT)));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b2.start_t = 1'b0;
      check("s5_rst_ctl", 32'(ctl2), 32'(0));
      check("s5_rst_taint", 32'({tnt2, b2.digit_sel, b2.digit_sel_t}), 32'(0));
      tick();
      done_at = -1;
      for (int c = 1; c <= 40; c++) begin
         if (b2.productDone) begin done_at = c; break; end
         tick();
      end
      b2.start = 1'b0;
      check("s5_held_start_done", 32'(done_at), 32'(8));
      tick();
      check("s5_back_idle", 32'(ctl2), 32'(0));

      // Scenario 6: DIGIT=4, only digit 1 nonzero and tainted
      do_reset();
      b4.multiplierReg   = 8'h30;
      b4.multiplierReg_t = 8'h10;
      b4.start = 1'b1;
      tick();
      b4.start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         check($sformatf("s6_ctl_c%0d", k), 32'(ctl4), 32'(ctl_of(SEQ_F[k-1])));
         check($sformatf("s6_sel_c%0d", k), 32'(b4.digit_sel), 32'(SEL_F[k-1]));
         check($sformatf("s6_sel_t_c%0d", k), 32'(b4.digit_sel_t), (k <= 2) ? 32'(0) : 32'(4'hF));
         check($sformatf("s6_taint_c%0d", k), 32'(tnt4), (k <= 2) ? 32'(0) : 32'(7'h7F));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_ctrl_taint_radix.md
Name: mult_ctrl_taint_radix

Overview:
Next-generation control FSM for the sequential shift-add multiplier, with gate-level taint tracking (IFT) on every control signal.
- Scans the multiplier DIGIT bits per iteration instead of one bit per state.
- Uses a compact state encoding plus a digit counter in place of a 2*WIDTH+3 state space.
- Adds a busy/done handshake and an abort input, each with shadow taint.
- Drives the existing accumulator/multiplicand datapath; the datapath forms digit_sel*multiplicand.

Parameters:
WIDTH, 1024, multiplier operand width in bits
DIGIT, 1, multiplier bits consumed per iteration; WIDTH % DIGIT == 0 is required (elaboration error otherwise)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin operation (sampled in IDLE only)
start_t  input  1  taint of start
abort  input  1  cancel current operation
abort_t  input  1  taint of abort
multiplierReg  input  WIDTH  multiplier register from datapath, stable during operation
multiplierReg_t  input  WIDTH  per-bit taint of multiplierReg
busy  output  1  high in every state except IDLE
busy_t  output  1  taint of busy
productDone  output  1  one-cycle pulse in DONE
productDone_t  output  1  taint of productDone
mdld, mrld, rsclear  output  1 each  operand load / accumulator clear (INIT)
rsload  output  1  accumulator add (ADD)
rsshr  output  1  accumulator shift right by DIGIT (SHIFT)
digit_sel  output  DIGIT  multiple of multiplicand to add; current digit in ADD, else 0
mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t  output  1 each  taints
digit_sel_t  output  DIGIT  per-bit taint of digit_sel

Behaviour:
- Constants: N = WIDTH/DIGIT; IDX_W = $clog2(N) (minimum 1); registered idx[IDX_W-1:0]; digit(i) = multiplierReg[i*DIGIT +: DIGIT].
- States: IDLE, INIT, ADD, SHIFT, DONE. Outputs are Moore, decoded from state.
- IDLE: all datapath strobes 0. If start, go to INIT.
- INIT: mdld=mrld=rsclear=1; idx<=0. Go to ADD if digit(0)!=0, else SHIFT.
- ADD: rsload=1, digit_sel=digit(idx). Go to SHIFT.
- SHIFT: rsshr=1.
  - If idx==N-1, go to DONE.
  - Else idx<=idx+1; go to ADD if digit(idx+1)!=0, else SHIFT.
- DONE: productDone=1. Go to IDLE. DONE performs no datapath op.
- Latency: start seen at cycle t gives productDone at cycle t+2+N+A, where A is the number of nonzero digits.
- start while busy: ignored.
- abort in any non-IDLE state: go to IDLE next cycle, idx<=0, no productDone. abort in IDLE: no effect. abort has priority over the normal transition.
- rst (any state, including mid-operation): state=IDLE, idx=0, ctl_t=0, so every output and every taint output is 0 the cycle after reset.
- Taint:
  - A single sticky register ctl_t represents taint on control flow and timing.
  - ctl_t <= ctl_t | (start_t in IDLE) | (abort_t in non-IDLE) | (|taint of the digit examined on each INIT/SHIFT decision).
  - Only rst clears ctl_t. Tainted control flow makes all later timing tainted.
  - Every 1-bit output _t equals ctl_t in all states. Constant-0 values are tainted too, because their timing is tainted.
  - digit_sel_t[j] = ctl_t | (state==ADD & multiplierReg_t[idx*DIGIT+j]).

Decomposition:
- Shared package mult_taint_pkg holds:
  - state localparams: IDLE=0, INIT=1, ADD=2, SHIFT=3, DONE=4; 3-bit state
  - the helper function computing IDX_W
- One sub-module: mult_digit_mux_taint (WIDTH, DIGIT).
  - Inputs: multiplierReg, multiplierReg_t, index.
  - Outputs: digit, digit_t, digit_nz, digit_any_t.
  - It is instantiated twice: for idx (ADD output) and for the next index (transition decision).

Test Plan:
1. WIDTH=8, DIGIT=2, multiplierReg=8'b10_00_00_01, start pulse at cycle 0, no taint.
   - Required: INIT c1, ADD(sel=1) c2, SHIFT c3, SHIFT c4, SHIFT c5, ADD(sel=2) c6, SHIFT c7, DONE c8.
   - Required: productDone=1 only at c8; every _t stays 0.
2. WIDTH=8, DIGIT=1, multiplierReg=8'hFF: productDone at cycle 18 (2+8+8). multiplierReg=0: productDone at cycle 10.
3. Same as scenario 1 with multiplierReg_t=8'h04 (digit 1 tainted).
   - Required: all 1-bit _t outputs are 0 through c3 and 1 from c4 on.
   - Required: ctl_t stays 1 after returning to IDLE until rst.
4. abort asserted at c4 of scenario 1.
   - Required: IDLE at c5, busy=0, no productDone.
   - Required: a new start at c6 yields productDone at c14.
5. rst asserted at c3 mid-operation with start_t=1 earlier: all outputs and taints read 0 at c4. start held high during busy has no effect on the sequence.
6. DIGIT=4, WIDTH=8, multiplierReg=8'h30, multiplierReg_t=8'h10.
   - Required: ADD only for digit 1 with digit_sel=3.
   - Required: digit_sel_t=4'b1111 in that ADD (ctl_t set at that digit's decision); digit_sel_t=4'b0000 in every cycle before it.
